bank_decoder: RTL and testbench
===============================

BANK_DECODER -- requirements
Module: bank_decoder

Interface
REQ-001 Parameter WDOG_LIMIT, default 8, number of vblank rising edges without a kick before a watchdog reset fires.
REQ-002 Parameter WDOG_PULSE, default 16, length in clk cycles of the watchdog reset pulse.
REQ-003 clk  input  1  system clock; every state element updates on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 address  input  16  CPU address bus.
REQ-006 data_in  input  8  CPU write data.
REQ-007 rw  input  1  CPU read/write, 1 = read, 0 = write.
REQ-008 cpu_en  input  1  one-clk CPU cycle strobe; writes are only accepted when it is 1.
REQ-009 vblank  input  1  video vertical blank level.
REQ-010 rom_address  output  13  address[12:0] passed to the ROM array.
REQ-011 rom0_n, rom1_n, rom2_n  output  1 each  active-low ROM region selects.
REQ-012 bank0_n, bank1_n  output  1 each  active-low bank selects for the banked region.
REQ-013 wdog_reset_n  output  1  active-low CPU reset request.

Function
REQ-014 rom_address SHALL equal address[12:0] combinationally.
REQ-015 Region decode SHALL be combinational, with exactly one or none of the selects low:
- rom1_n low for 0xA000-0xBFFF (banked)
- rom0_n low for 0xC000-0xDFFF (banked)
- rom2_n low for 0xE000-0xFFFF
- all selects high for any other address.
REQ-016 The selects SHALL be independent of rw, so that writes to ROM space still assert a select, and the ROM array ignores the write.
REQ-017 A bank write is accepted only when all of the following are true in one clk cycle: cpu_en=1, rw=0, address=0x9F80.
- On acceptance, bank_sel <= data_in[0]. Data bits 7:1 are ignored.
REQ-018 The bank select outputs SHALL be driven from the bank_sel register: bank0_n = ~bank_sel and bank1_n = bank_sel. Both outputs change on the clk edge after the accepted write.
REQ-019 A watchdog kick is accepted only when all of the following are true in one clk cycle: cpu_en=1, rw=0, address=0x9E00. The data value does not matter.
REQ-020 vblank SHALL be registered once. A rising edge is detected when the current vblank=1 and the registered value=0, giving one detection per edge.
REQ-021 The watchdog SHALL be a 2-state FSM, COUNT and PULSE, with a counter wcnt sized for WDOG_LIMIT and a counter pcnt sized for WDOG_PULSE.
REQ-022 COUNT state behaviour:
- A kick sets wcnt <= 0.
- Otherwise, a vblank edge increments wcnt.
- When the increment makes wcnt equal WDOG_LIMIT, go to PULSE with pcnt <= 0.
REQ-023 If a kick and a vblank edge occur in the same cycle, the kick SHALL win: wcnt becomes 0 and there is no transition.
REQ-024 PULSE state behaviour:
- wdog_reset_n is held 0.
- pcnt increments every cycle.
- When pcnt = WDOG_PULSE-1, go to COUNT with wcnt <= 0.
- Kicks and vblank edges are ignored.
REQ-025 wdog_reset_n SHALL be registered: it is 0 for exactly WDOG_PULSE cycles, starting on the clk edge that enters PULSE, and 1 at all other times.
REQ-026 wcnt SHALL never exceed WDOG_LIMIT and SHALL never wrap.
REQ-027 Bank writes SHALL still be accepted while in PULSE.

Reset
REQ-028 While reset_n=0 at a clk edge, the following SHALL all be loaded: bank_sel=0 (bank0_n=1, bank1_n=0), wcnt=0, pcnt=0, state=COUNT, the registered vblank=0, and wdog_reset_n=1.
REQ-029 Bank writes and kicks presented during reset SHALL be ignored.
REQ-030 Asserting reset in the middle of a pulse SHALL end the pulse on that same edge.
REQ-031 The combinational decode outputs SHALL stay valid during reset.

Verification
REQ-032 Sweep address 0x0000-0xFFFF with rw=1 -> rom1_n low only for 0xA000-0xBFFF, rom0_n low only for 0xC000-0xDFFF, rom2_n low only for 0xE000-0xFFFF, and rom_address = address[12:0] throughout.
REQ-033 Write 0x01 to 0x9F80 with cpu_en=1 -> on the next edge bank0_n=0, bank1_n=1. Then write 0xFE -> bank0_n=1, bank1_n=0. Repeat the 0x01 write with cpu_en=0 or rw=1 -> no change.
REQ-034 Apply 8 vblank pulses with no kick -> wdog_reset_n=0 for exactly 16 clk starting on the edge after the 8th vblank rise, then returns to 1. The next pulse requires 8 further edges.
REQ-035 Kick at 0x9E00 after 7 vblank edges, then apply 7 more edges -> wdog_reset_n stays 1. Kick on the same cycle as the 8th edge -> no pulse.
REQ-036 Hold vblank=1 for 1000 clk -> counts as a single edge.
REQ-037 Assert reset_n=0 for 1 clk at pulse cycle 5 -> wdog_reset_n=1 on that edge, bank0_n=1, and the FSM is in COUNT with wcnt=0. A kick or bank write issued during reset has no effect.

Source files
------------

// File: rtl/bank_decoder_if.sv
// CPU-side bus of the bank decoder: address/data strobes in, ROM selects,
// bank selects and watchdog reset out.
interface bank_decoder_if;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic        rw;
  logic        cpu_en;
  logic        vblank;
  logic [12:0] rom_address;
  logic        rom0_n;
  logic        rom1_n;
  logic        rom2_n;
  logic        bank0_n;
  logic        bank1_n;
  logic        wdog_reset_n;

  modport master (
    output address, data_in, rw, cpu_en, vblank,
    input  rom_address, rom0_n, rom1_n, rom2_n, bank0_n, bank1_n, wdog_reset_n
  );

  modport slave (
    input  address, data_in, rw, cpu_en, vblank,
    output rom_address, rom0_n, rom1_n, rom2_n, bank0_n, bank1_n, wdog_reset_n
  );
endinterface

// File: rtl/bank_decoder.sv
// ROM region decoder with a writable bank-select latch and a vblank-driven
// watchdog that issues a fixed-length CPU reset pulse when not kicked.
module bank_decoder #(
  parameter int unsigned WDOG_LIMIT = 8,
  parameter int unsigned WDOG_PULSE = 16
) (
  input logic           clk,
  input logic           reset_n,
  bank_decoder_if.slave bus
);
  localparam int unsigned WW = $clog2(WDOG_LIMIT + 1);
  localparam int unsigned PW = (WDOG_PULSE > 1) ? $clog2(WDOG_PULSE) : 1;

  typedef enum logic {
    COUNT = 1'b0,
    PULSE = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [WW-1:0] r_wcnt;
  logic [WW-1:0] w_wcnt_nxt;
  logic [WW-1:0] w_wcnt_inc;
  logic [PW-1:0] r_pcnt;
  logic [PW-1:0] w_pcnt_nxt;
  logic          r_bank_sel;
  logic          r_vblank_d;
  logic          r_wdog_n;
  logic          w_bank_wr;
  logic          w_kick;
  logic          w_vb_edge;
  logic          w_unused;

  assign bus.rom_address = bus.address[12:0];
  assign bus.rom1_n      = ~(bus.address[15:13] == 3'b101);
  assign bus.rom0_n      = ~(bus.address[15:13] == 3'b110);
  assign bus.rom2_n      = ~(bus.address[15:13] == 3'b111);

  assign bus.bank0_n      = ~r_bank_sel;
  assign bus.bank1_n      = r_bank_sel;
  assign bus.wdog_reset_n = r_wdog_n;

  assign w_bank_wr = bus.cpu_en & ~bus.rw & (bus.address == 16'h9F80);
  assign w_kick    = bus.cpu_en & ~bus.rw & (bus.address == 16'h9E00);
  assign w_vb_edge = bus.vblank & ~r_vblank_d;
  assign w_unused  = ^bus.data_in[7:1];

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_pcnt_nxt  = r_pcnt;
    w_wcnt_inc  = r_wcnt + 1'b1;
    case (r_state)
      COUNT: begin
        // A kick overrides a coincident vblank edge.
        if (w_kick) begin
          w_wcnt_nxt = '0;
        end else if (w_vb_edge) begin
          w_wcnt_nxt = w_wcnt_inc;
          if (w_wcnt_inc == WW'(WDOG_LIMIT)) begin
            w_state_nxt = PULSE;
            w_pcnt_nxt  = '0;
          end
        end
      end
      PULSE: begin
        if (r_pcnt == PW'(WDOG_PULSE - 1)) begin
          w_state_nxt = COUNT;
          w_wcnt_nxt  = '0;
          w_pcnt_nxt  = '0;
        end else begin
          w_pcnt_nxt = r_pcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = COUNT;
        w_wcnt_nxt  = '0;
        w_pcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= COUNT;
      r_wcnt     <= '0;
      r_pcnt     <= '0;
      r_bank_sel <= 1'b0;
      r_vblank_d <= 1'b0;
      r_wdog_n   <= 1'b1;
    end else begin
      if (w_bank_wr) begin
        r_bank_sel <= bus.data_in[0];
      end
      r_vblank_d <= bus.vblank;
      r_state    <= w_state_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_pcnt     <= w_pcnt_nxt;
      // Registered so the pulse begins on the very edge that enters PULSE.
      r_wdog_n   <= (w_state_nxt != PULSE);
    end
  end
endmodule

// File: tb/tb_bank_decoder.sv
// Scoreboard bench for bank_decoder: decode sweep, bank latch, watchdog
// timeout/kick/long-vblank and reset-during-pulse scenarios.
module tb_bank_decoder;
  logic clk;
  logic reset_n;
  int   passed;
  int   total;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  bank_decoder_if bus ();

  bank_decoder #(
    .WDOG_LIMIT(8),
    .WDOG_PULSE(16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.address = 16'h0000;
    bus.data_in = 8'h00;
    bus.rw      = 1'b1;
    bus.cpu_en  = 1'b0;
  endtask

  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d,
                           input logic r, input logic en);
    bus.address = a;
    bus.data_in = d;
    bus.rw      = r;
    bus.cpu_en  = en;
    tick();
    idle();
  endtask

  task automatic vb_rise();
    bus.vblank = 1'b1;
    tick();
  endtask

  task automatic vb_fall();
    bus.vblank = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    bus.vblank = 1'b0;
    reset_n = 1'b0;
    bus.address = 16'hA123;
    tick();
    tick();
    exp_q.push_back(16'h0001);
    exp_v = exp_q.pop_front();
    total++;
    if (bus.wdog_reset_n !== exp_v[0]) $display("FAIL reset_wdog got=%b exp=%b", bus.wdog_reset_n, exp_v[0]);
    else passed++;
    exp_q.push_back({14'd0, 1'b0, 1'b1});
    exp_v = exp_q.pop_front();
    total++;
    if ({bus.bank1_n, bus.bank0_n} !== exp_v[1:0]) $display("FAIL reset_bank got=%b exp=%b", {bus.bank1_n, bus.bank0_n}, exp_v[1:0]);
    else passed++;
    exp_q.push_back({3'b0, 13'h0123});
    exp_v = exp_q.pop_front();
    total++;
    if ({bus.rom2_n, bus.rom1_n, bus.rom0_n, bus.rom_address} !== {3'b101, exp_v[12:0]})
      $display("FAIL reset_decode got=%b_%h exp=101_%h", {bus.rom2_n, bus.rom1_n, bus.rom0_n}, bus.rom_address, exp_v[12:0]);
    else passed++;
    reset_n = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_decode();
    int errs;
    logic [15:0] bad;
    logic [15:0] got;
    errs = 0;
    bad = 16'h0;
    bus.rw = 1'b1;
    bus.cpu_en = 1'b0;
    for (int a = 0; a < 65536; a++) begin
      logic [15:0] av;
      logic [2:0]  sel;
      av = 16'(a);
      bus.address = av;
      sel = 3'b111;
      if (av >= 16'hA000 && av <= 16'hBFFF) sel = 3'b101;
      if (av >= 16'hC000 && av <= 16'hDFFF) sel = 3'b110;
      if (av >= 16'hE000) sel = 3'b011;
      exp_q.push_back({sel, av[12:0]});
      #1;
      exp_v = exp_q.pop_front();
      got = {bus.rom2_n, bus.rom1_n, bus.rom0_n, bus.rom_address};
      if (got !== exp_v) begin
        if (errs == 0) bad = av;
        errs++;
      end
    end
    total++;
    if (errs != 0) $display("FAIL decode_sweep errors=%0d first_addr=%h exp=0", errs, bad);
    else passed++;
    // write into ROM space still selects
    bus.address = 16'hC456;
    bus.rw = 1'b0;
    #1;
    exp_q.push_back({3'b110, 13'h0456});
    exp_v = exp_q.pop_front();
    total++;
    if ({bus.rom2_n, bus.rom1_n, bus.rom0_n, bus.rom_address} !== exp_v)
      $display("FAIL decode_write got=%b exp=%b", {bus.rom2_n, bus.rom1_n, bus.rom0_n}, exp_v[15:13]);
    else passed++;
    idle();
    tick();
  endtask

  task automatic test_bank();
    logic [7:0] dv [5];
    logic       rv [5];
    logic       ev [5];
    logic [15:0] av [5];
    logic       model;
    dv = '{8'h01, 8'hFE, 8'h01, 8'h01, 8'h01};
    rv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ev = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    av = '{16'h9F80, 16'h9F80, 16'h9F80, 16'h9F80, 16'h9F81};
    model = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (ev[i] && !rv[i] && av[i] == 16'h9F80) model = dv[i][0];
      exp_q.push_back({14'd0, model, ~model});
      cpu_cycle(av[i], dv[i], rv[i], ev[i]);
      exp_v = exp_q.pop_front();
      total++;
      if ({bus.bank1_n, bus.bank0_n} !== exp_v[1:0])
        $display("FAIL bank_write%0d got=%b exp=%b", i, {bus.bank1_n, bus.bank0_n}, exp_v[1:0]);
      else passed++;
    end
    cpu_cycle(16'h9F80, 8'h01, 1'b0, 1'b1);
  endtask

  // After the pulse has started: count low cycles, bounded.
  task automatic measure_pulse(input string nm);
    int cnt;
    cnt = 0;
    while (bus.wdog_reset_n === 1'b0 && cnt < 100) begin
      cnt++;
      tick();
    end
    exp_q.push_back(16'd16);
    exp_v = exp_q.pop_front();
    total++;
    if (cnt !== int'(exp_v)) $display("FAIL %s_len got=%0d exp=%0d", nm, cnt, exp_v);
    else passed++;
  endtask

  task automatic pulses_expect_high(input int n, input string nm);
    int lows;
    lows = 0;
    for (int i = 0; i < n; i++) begin
      vb_rise();
      if (bus.wdog_reset_n !== 1'b1) lows++;
      vb_fall();
      if (bus.wdog_reset_n !== 1'b1) lows++;
    end
    exp_q.push_back(16'd0);
    exp_v = exp_q.pop_front();
    total++;
    if (lows !== int'(exp_v)) $display("FAIL %s_high low_samples=%0d exp=%0d", nm, lows, exp_v);
    else passed++;
  endtask

  task automatic final_edge_expect_pulse(input string nm);
    vb_rise();
    exp_q.push_back(16'd0);
    exp_v = exp_q.pop_front();
    total++;
    if (bus.wdog_reset_n !== exp_v[0]) $display("FAIL %s_start got=%b exp=%b", nm, bus.wdog_reset_n, exp_v[0]);
    else passed++;
    bus.vblank = 1'b0;
    measure_pulse(nm);
  endtask

  task automatic test_timeout();
    do_reset();
    tick();
    pulses_expect_high(7, "to1");
    final_edge_expect_pulse("to1");
    exp_q.push_back(16'd1);
    exp_v = exp_q.pop_front();
    total++;
    if (bus.wdog_reset_n !== exp_v[0]) $display("FAIL to1_release got=%b exp=%b", bus.wdog_reset_n, exp_v[0]);
    else passed++;
    tick();
    pulses_expect_high(7, "to2");
    final_edge_expect_pulse("to2");
  endtask

  task automatic test_kick();
    do_reset();
    tick();
    pulses_expect_high(7, "kick_a");
    cpu_cycle(16'h9E00, 8'h5A, 1'b0, 1'b1);
    pulses_expect_high(7, "kick_b");
    // kick coincides with the 8th edge
    bus.vblank = 1'b1;
    cpu_cycle(16'h9E00, 8'h00, 1'b0, 1'b1);
    vb_fall();
    pulses_expect_high(7, "kick_c");
    final_edge_expect_pulse("kick_c");
  endtask

  task automatic test_long_vblank();
    do_reset();
    tick();
    bus.vblank = 1'b1;
    repeat (1000) tick();
    vb_fall();
    pulses_expect_high(6, "longvb");
    final_edge_expect_pulse("longvb");
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    tick();
    pulses_expect_high(7, "rmp");
    vb_rise();
    bus.vblank = 1'b0;
    // bank write accepted during PULSE
    cpu_cycle(16'h9F80, 8'h01, 1'b0, 1'b1);
    exp_q.push_back({14'd0, 1'b1, 1'b0});
    exp_v = exp_q.pop_front();
    total++;
    if ({bus.bank1_n, bus.bank0_n, bus.wdog_reset_n} !== {exp_v[1:0], 1'b0})
      $display("FAIL rmp_bank_in_pulse got=%b exp=%b0", {bus.bank1_n, bus.bank0_n, bus.wdog_reset_n}, exp_v[1:0]);
    else passed++;
    repeat (3) tick();
    reset_n = 1'b0;
    cpu_cycle(16'h9F80, 8'h01, 1'b0, 1'b1);
    reset_n = 1'b1;
    exp_q.push_back({13'd0, 1'b0, 1'b1, 1'b1});
    exp_v = exp_q.pop_front();
    total++;
    if ({bus.bank1_n, bus.bank0_n, bus.wdog_reset_n} !== exp_v[2:0])
      $display("FAIL rmp_reset got=%b exp=%b", {bus.bank1_n, bus.bank0_n, bus.wdog_reset_n}, exp_v[2:0]);
    else passed++;
    pulses_expect_high(7, "rmp_after");
    final_edge_expect_pulse("rmp_after");
    // kick during reset must not matter: reset then count 8 fresh edges
    pulses_expect_high(5, "rmp_k");
    reset_n = 1'b0;
    cpu_cycle(16'h9E00, 8'h00, 1'b0, 1'b1);
    reset_n = 1'b1;
    pulses_expect_high(7, "rmp_k2");
    final_edge_expect_pulse("rmp_k2");
  endtask

  initial begin
    passed = 0;
    total = 0;
    reset_n = 1'b0;
    bus.vblank = 1'b0;
    idle();
    tick();
    test_reset();
    test_decode();
    test_bank();
    test_timeout();
    test_kick();
    test_long_vblank();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
